// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Imported by the top level and the shift core.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Load/shift register with bit counter and registered frame flags.
// Loading always wins over shifting; shifting past the last bit empties it.
module piso_shift_core
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             first,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // sreg holds the bits still to be presented after the current one
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      sout    <= 1'b0;
      first   <= 1'b0;
      last    <= 1'b0;
    end else if (load) begin
      sout    <= head(load_data);
      sreg    <= adv(load_data);
      bit_cnt <= '0;
      first   <= 1'b1;
      last    <= 1'b0;
    end else if (shift_en) begin
      if (last) begin
        sreg    <= '0;
        bit_cnt <= '0;
        sout    <= 1'b0;
        first   <= 1'b0;
        last    <= 1'b0;
      end else begin
        sout    <= head(sreg);
        sreg    <= adv(sreg);
        bit_cnt <= bit_cnt + 1'b1;
        first   <= 1'b0;
        last    <= (bit_cnt == CW'(WIDTH - 2));
      end
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer.
// Words stream back-to-back; the hold is refilled while the shifter runs.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             accept;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] load_data;

  assign din_ready  = !hold_valid;
  assign accept     = din_valid && din_ready;
  assign sout_valid = (state == ST_SHIFT);
  assign busy       = (state == ST_SHIFT) || hold_valid;

  always_comb begin
    load      = 1'b0;
    shift_en  = 1'b0;
    load_data = din;
    unique case (state)
      ST_IDLE: load = accept;
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (sout_last) begin
          if (hold_valid) begin
            load      = 1'b1;
            load_data = hold;
          end else begin
            load = accept;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) state <= ST_SHIFT;
        ST_SHIFT: begin
          if (sout_last) begin
            if (hold_valid) hold_valid <= 1'b0;
            else if (!accept) state <= ST_IDLE;
          end else if (accept) begin
            hold       <= din;
            hold_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift_en  (shift_en),
    .sout      (sout),
    .first     (sout_first),
    .last      (sout_last)
  );

endmodule
